// File: rtl/cluster_pkg.sv
// Shared constants, sizing helper and FSM encoding for the cluster extractor.
package cluster_pkg;

    // Ceiling log2 for elaboration-time sizing; clog2(1) == 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            r = ((1 << i) < value) ? (i + 1) : r;
        end
        return r;
    endfunction

    localparam int ADRB = clog2(768);
    localparam int CNTB = clog2(8 + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/seg_priority_encoder.sv
// Combinational priority encoder for one frame segment: isolates the winning
// set bit (lowest, or highest when MSB_FIRST) and reports its offset.
module seg_priority_encoder
    import cluster_pkg::*;
#(
    parameter int SEGSIZE   = 48,
    parameter int MSB_FIRST = 0,
    parameter int OFF_W     = clog2(SEGSIZE)
) (
    input  logic [SEGSIZE-1:0] seg_bits,
    output logic               active,
    output logic [OFF_W-1:0]   bit_offset,
    output logic [SEGSIZE-1:0] clr_mask
);

    logic [SEGSIZE-1:0] src_s;
    logic [SEGSIZE-1:0] iso_s;

    // MSB mode mirrors the segment so one two's-complement isolate serves both orders.
    always_comb begin
        src_s = seg_bits;
        for (int i = 0; i < SEGSIZE; i++) begin
            src_s[i] = (MSB_FIRST != 0) ? seg_bits[SEGSIZE-1-i] : seg_bits[i];
        end
        iso_s    = src_s & (~src_s + SEGSIZE'(1));
        clr_mask = iso_s;
        for (int i = 0; i < SEGSIZE; i++) begin
            clr_mask[i] = (MSB_FIRST != 0) ? iso_s[SEGSIZE-1-i] : iso_s[i];
        end
        bit_offset = '0;
        for (int i = 0; i < SEGSIZE; i++) begin
            bit_offset = clr_mask[i] ? (bit_offset | OFF_W'(i)) : bit_offset;
        end
    end

    assign active = |seg_bits;

endmodule

// File: rtl/cluster_extractor.sv
// Latches a valid-pattern frame and emits set-bit addresses one per accepted
// beat in priority order, capped at MXCLUSTERS with an overflow flag.
module cluster_extractor
    import cluster_pkg::*;
#(
    parameter int MXVPF      = 768,
    parameter int MXSEGS     = 16,
    parameter int MXCLUSTERS = 8,
    parameter int MSB_FIRST  = 0,
    parameter int ADR_W      = clog2(MXVPF),
    parameter int CNT_W      = clog2(MXCLUSTERS + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             latch_pulse,
    input  logic [MXVPF-1:0] vpfs_in,
    input  logic             cluster_rdy,
    output logic             cluster_vld,
    output logic [ADR_W-1:0] cluster_adr,
    output logic [CNT_W-1:0] cluster_cnt,
    output logic             frame_done,
    output logic             overflow
);

    localparam int SEGSIZE = MXVPF / MXSEGS;
    localparam int OFF_W   = (clog2(SEGSIZE) > 0) ? clog2(SEGSIZE) : 1;
    localparam int SEG_W   = (clog2(MXSEGS) > 0) ? clog2(MXSEGS) : 1;

    state_e             state_r, state_s;
    logic [MXVPF-1:0]   work_r, work_s, clr_full_s, work_clr_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s, cnt_inc_s;
    logic               vld_r, vld_s, ovf_r, ovf_s, done_s;
    logic [ADR_W-1:0]   adr_r, adr_s, sel_adr_s;
    logic [CNT_W-1:0]   ocnt_r, ocnt_s;
    logic [MXSEGS-1:0]  seg_act_s;
    logic [OFF_W-1:0]   seg_off_s [MXSEGS];
    logic [SEGSIZE-1:0] seg_clr_s [MXSEGS];
    logic [SEG_W-1:0]   sel_s;
    logic               advance_s;

    for (genvar g = 0; g < MXSEGS; g++) begin : g_seg
        seg_priority_encoder #(
            .SEGSIZE   (SEGSIZE),
            .MSB_FIRST (MSB_FIRST),
            .OFF_W     (OFF_W)
        ) u_enc (
            .seg_bits   (work_r[g*SEGSIZE +: SEGSIZE]),
            .active     (seg_act_s[g]),
            .bit_offset (seg_off_s[g]),
            .clr_mask   (seg_clr_s[g])
        );
    end

    // Cross-segment priority select, full-width clear mask and address.
    always_comb begin
        sel_s = '0;
        for (int s = 0; s < MXSEGS; s++) begin
            int idx;
            idx   = (MSB_FIRST != 0) ? s : (MXSEGS - 1 - s);
            sel_s = seg_act_s[idx] ? SEG_W'(idx) : sel_s;
        end
        clr_full_s = '0;
        for (int s = 0; s < MXSEGS; s++) begin
            clr_full_s[s*SEGSIZE +: SEGSIZE] = (SEG_W'(s) == sel_s) ? seg_clr_s[s] : '0;
        end
        work_clr_s = work_r & ~clr_full_s;
        sel_adr_s  = ADR_W'(sel_s) * ADR_W'(SEGSIZE) + ADR_W'(seg_off_s[sel_s]);
    end

    // Next-state and datapath; the last address is registered straight into DRAIN
    // so frame_done coincides with its acceptance.
    always_comb begin
        state_s   = state_r;
        work_s    = work_r;
        cnt_s     = cnt_r;
        vld_s     = vld_r;
        adr_s     = adr_r;
        ocnt_s    = ocnt_r;
        ovf_s     = ovf_r;
        done_s    = 1'b0;
        advance_s = !vld_r || cluster_rdy;
        cnt_inc_s = cnt_r + CNT_W'(1);
        if (latch_pulse) begin
            work_s  = vpfs_in;
            cnt_s   = '0;
            ovf_s   = 1'b0;
            vld_s   = 1'b0;
            state_s = RUN;
        end else begin
            case (state_r)
                IDLE: begin
                    vld_s = 1'b0;
                end
                RUN: begin
                    if (!advance_s) begin
                        state_s = RUN;
                    end else if ((work_r == '0) || (cnt_r == CNT_W'(MXCLUSTERS))) begin
                        vld_s   = 1'b0;
                        state_s = DRAIN;
                    end else begin
                        adr_s  = sel_adr_s;
                        ocnt_s = cnt_r;
                        vld_s  = 1'b1;
                        work_s = work_clr_s;
                        cnt_s  = cnt_inc_s;
                        ovf_s  = (cnt_inc_s == CNT_W'(MXCLUSTERS)) && (work_clr_s != '0);
                        if ((work_clr_s == '0) || (cnt_inc_s == CNT_W'(MXCLUSTERS))) begin
                            state_s = DRAIN;
                        end else begin
                            state_s = RUN;
                        end
                    end
                end
                DRAIN: begin
                    if (advance_s) begin
                        done_s  = 1'b1;
                        vld_s   = 1'b0;
                        state_s = IDLE;
                    end else begin
                        state_s = DRAIN;
                    end
                end
                default: begin
                    vld_s   = 1'b0;
                    state_s = IDLE;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Working register, count and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            work_r <= '0;
            cnt_r  <= '0;
            vld_r  <= 1'b0;
            adr_r  <= '0;
            ocnt_r <= '0;
            ovf_r  <= 1'b0;
        end else begin
            work_r <= work_s;
            cnt_r  <= cnt_s;
            vld_r  <= vld_s;
            adr_r  <= adr_s;
            ocnt_r <= ocnt_s;
            ovf_r  <= ovf_s;
        end
    end

    assign cluster_vld = vld_r;
    assign cluster_adr = adr_r;
    assign cluster_cnt = ocnt_r;
    assign overflow    = ovf_r;
    assign frame_done  = done_s;

endmodule

// File: tb/tb_cluster_extractor.sv
// Directed bench for cluster_extractor: LSB-first instance plus an MSB-first
// instance sharing the same stimulus.
module tb_cluster_extractor;
    import cluster_pkg::*;

    logic              clock;
    logic              reset_n;
    logic              latch_pulse;
    logic [767:0]      vpfs_in;
    logic              cluster_rdy;
    logic              vld_l, done_l, ovf_l;
    logic [ADRB-1:0]   adr_l;
    logic [CNTB-1:0]   cnt_l;
    logic              vld_m, done_m, ovf_m;
    logic [ADRB-1:0]   adr_m;
    logic [CNTB-1:0]   cnt_m;
    logic [767:0]      v;
    int                n_cmp;
    int                n_err;

    cluster_extractor #(.MSB_FIRST(0)) u_lsb (
        .clock       (clock),
        .reset_n     (reset_n),
        .latch_pulse (latch_pulse),
        .vpfs_in     (vpfs_in),
        .cluster_rdy (cluster_rdy),
        .cluster_vld (vld_l),
        .cluster_adr (adr_l),
        .cluster_cnt (cnt_l),
        .frame_done  (done_l),
        .overflow    (ovf_l)
    );

    cluster_extractor #(.MSB_FIRST(1)) u_msb (
        .clock       (clock),
        .reset_n     (reset_n),
        .latch_pulse (latch_pulse),
        .vpfs_in     (vpfs_in),
        .cluster_rdy (cluster_rdy),
        .cluster_vld (vld_m),
        .cluster_adr (adr_m),
        .cluster_cnt (cnt_m),
        .frame_done  (done_m),
        .overflow    (ovf_m)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic latch_frame(input logic [767:0] f);
        vpfs_in     = f;
        latch_pulse = 1'b1;
        tick();
        latch_pulse = 1'b0;
    endtask

    task automatic chk_beat(input string tag, input logic [31:0] adr, input logic [31:0] cnt, input logic [31:0] done);
        chk({tag, "_vld"}, 32'(vld_l), 32'd1);
        chk({tag, "_adr"}, 32'(adr_l), adr);
        chk({tag, "_cnt"}, 32'(cnt_l), cnt);
        chk({tag, "_done"}, 32'(done_l), done);
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        reset_n     = 1'b0;
        latch_pulse = 1'b0;
        vpfs_in     = '0;
        cluster_rdy = 1'b0;
        #3;
        chk("rst_vld", 32'(vld_l), 32'd0);
        chk("rst_adr", 32'(adr_l), 32'd0);
        chk("rst_cnt", 32'(cnt_l), 32'd0);
        chk("rst_done", 32'(done_l), 32'd0);
        chk("rst_ovf", 32'(ovf_l), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Four scattered bits, continuous ready.
        cluster_rdy = 1'b1;
        v = '0; v[5] = 1'b1; v[47] = 1'b1; v[48] = 1'b1; v[700] = 1'b1;
        latch_frame(v);
        chk("f4_k_vld", 32'(vld_l), 32'd0);
        tick(); chk_beat("f4_b0", 32'd5, 32'd0, 32'd0);
        tick(); chk_beat("f4_b1", 32'd47, 32'd1, 32'd0);
        tick(); chk_beat("f4_b2", 32'd48, 32'd2, 32'd0);
        tick(); chk_beat("f4_b3", 32'd700, 32'd3, 32'd1);
        chk("f4_ovf", 32'(ovf_l), 32'd0);
        tick();
        chk("f4_end_vld", 32'(vld_l), 32'd0);
        chk("f4_end_done", 32'(done_l), 32'd0);

        // Bits 0..9: cap at eight addresses with overflow.
        v = '0;
        for (int i = 0; i < 10; i++) v[i] = 1'b1;
        latch_frame(v);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_beat("cap", 32'(i), 32'(i), (i == 7) ? 32'd1 : 32'd0);
        end
        chk("cap_ovf", 32'(ovf_l), 32'd1);
        tick();
        chk("cap_no9_vld", 32'(vld_l), 32'd0);
        chk("cap_ovf_hold", 32'(ovf_l), 32'd1);

        // Empty frame.
        latch_frame('0);
        chk("empty_k_vld", 32'(vld_l), 32'd0);
        chk("empty_k_done", 32'(done_l), 32'd0);
        chk("empty_ovf_clr", 32'(ovf_l), 32'd0);
        tick();
        chk("empty_k1_vld", 32'(vld_l), 32'd0);
        chk("empty_k1_done", 32'(done_l), 32'd1);
        chk("empty_k1_ovf", 32'(ovf_l), 32'd0);
        tick();
        chk("empty_k2_done", 32'(done_l), 32'd0);

        // Back-pressure: ready low for three cycles after the first beat.
        v = '0; v[100] = 1'b1; v[200] = 1'b1;
        latch_frame(v);
        tick(); chk_beat("stall_b0", 32'd100, 32'd0, 32'd0);
        cluster_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_beat("stall_hold", 32'd100, 32'd0, 32'd0);
        end
        cluster_rdy = 1'b1;
        tick(); chk_beat("stall_b1", 32'd200, 32'd1, 32'd1);
        tick();
        chk("stall_end_vld", 32'(vld_l), 32'd0);

        // Abandon a six-bit frame after two beats.
        v = '0;
        for (int i = 1; i < 7; i++) v[i] = 1'b1;
        latch_frame(v);
        tick(); chk_beat("ab_b0", 32'd1, 32'd0, 32'd0);
        tick(); chk_beat("ab_b1", 32'd2, 32'd1, 32'd0);
        v = '0; v[10] = 1'b1; v[20] = 1'b1;
        vpfs_in     = v;
        latch_pulse = 1'b1;
        chk("ab_latch_done", 32'(done_l), 32'd0);
        tick();
        latch_pulse = 1'b0;
        chk("ab_drop_vld", 32'(vld_l), 32'd0);
        tick(); chk_beat("ab_n0", 32'd10, 32'd0, 32'd0);
        tick(); chk_beat("ab_n1", 32'd20, 32'd1, 32'd1);
        tick();
        chk("ab_end_done", 32'(done_l), 32'd0);

        // Asynchronous reset mid-frame.
        v = '0; v[3] = 1'b1; v[4] = 1'b1;
        latch_frame(v);
        tick(); chk_beat("mr_b0", 32'd3, 32'd0, 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mr_vld", 32'(vld_l), 32'd0);
        chk("mr_adr", 32'(adr_l), 32'd0);
        chk("mr_cnt", 32'(cnt_l), 32'd0);
        chk("mr_done", 32'(done_l), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("mr_after_vld", 32'(vld_l), 32'd0);

        // MSB-first ordering on the mirrored instance.
        v = '0; v[5] = 1'b1; v[47] = 1'b1; v[48] = 1'b1; v[767] = 1'b1;
        latch_frame(v);
        tick();
        chk("msb_b0_vld", 32'(vld_m), 32'd1);
        chk("msb_b0_adr", 32'(adr_m), 32'd767);
        chk("msb_b0_cnt", 32'(cnt_m), 32'd0);
        tick();
        chk("msb_b1_adr", 32'(adr_m), 32'd48);
        tick();
        chk("msb_b2_adr", 32'(adr_m), 32'd47);
        tick();
        chk("msb_b3_adr", 32'(adr_m), 32'd5);
        chk("msb_b3_cnt", 32'(cnt_m), 32'd3);
        chk("msb_b3_done", 32'(done_m), 32'd1);
        chk("msb_b3_ovf", 32'(ovf_m), 32'd0);
        tick();
        chk("msb_end_vld", 32'(vld_m), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
